// File: rtl/sm_seq_divider.sv
// -----------------------------------------------------------------------------
// sm_seq_divider
// Multi-cycle restoring divider for sign-magnitude operands (1 sign bit on top
// of MAG_W magnitude bits). The magnitudes are divided by shift-and-subtract,
// one quotient bit per clock, MSB first. The signs are then applied: the
// quotient sign is the XOR of the operand signs and the remainder takes the
// dividend sign. A zero magnitude is always given sign 0.
// One operation runs at a time, with a start/done handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   start        operation request, sampled only while idle
//   dividend     sign-magnitude dividend, captured on an accepted start
//   divisor      sign-magnitude divisor, captured on an accepted start
//   busy         high during the MAG_W iteration cycles
//   done         one-cycle pulse; the result outputs are valid from this cycle
//   quotient     sign-magnitude quotient, held until the next done
//   remainder    sign-magnitude remainder, held until the next done
//   div_by_zero  divisor magnitude was zero, held until the next done
// -----------------------------------------------------------------------------
module sm_seq_divider #(
    parameter int MAG_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MAG_W:0]   dividend,
    input  logic [MAG_W:0]   divisor,
    output logic             busy,
    output logic             done,
    output logic [MAG_W:0]   quotient,
    output logic [MAG_W:0]   remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [MAG_W:0]     pr_q;       // partial remainder; one extra bit so the shifted value is never truncated
    logic [MAG_W-1:0]   sr_q;       // dividend bits shift out at the top while quotient bits shift in at the bottom
    logic [MAG_W-1:0]   dvs_q;      // captured divisor magnitude
    logic               sa_q;       // dividend sign, already cleared for a zero magnitude
    logic               sb_q;       // divisor sign

    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [MAG_W:0]     quot_q;
    logic [MAG_W:0]     rem_q;

    // One restoring-division step
    logic [MAG_W:0]     pr_shift_d;
    logic               ge_d;
    logic [MAG_W:0]     pr_d;
    logic [MAG_W-1:0]   sr_d;
    logic [MAG_W-1:0]   rem_mag_d;

    // Values seen at the input ports while idle
    logic               sa_in;
    logic               dvs_zero_in;

    always_comb begin
        pr_shift_d = {pr_q[MAG_W-1:0], sr_q[MAG_W-1]};
        ge_d       = (pr_shift_d >= {1'b0, dvs_q});
        pr_d       = ge_d ? (pr_shift_d - {1'b0, dvs_q}) : pr_shift_d;
        sr_d       = {sr_q[MAG_W-2:0], ge_d};
        // pr is always below the divisor after a step, so the top bit is zero
        rem_mag_d  = pr_d[MAG_W-1:0];
    end

    // -0 as a dividend behaves exactly like +0
    assign sa_in       = dividend[MAG_W] & (|dividend[MAG_W-1:0]);
    assign dvs_zero_in = ~(|divisor[MAG_W-1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            sr_q    <= '0;
            dvs_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q  <= sa_in;
                        sb_q  <= divisor[MAG_W];
                        dvs_q <= divisor[MAG_W-1:0];
                        sr_q  <= dividend[MAG_W-1:0];
                        pr_q  <= '0;
                        cnt_q <= CNT_W'(MAG_W - 1);
                        if (dvs_zero_in) begin
                            // The result is available right away: a saturated
                            // quotient that keeps the combined sign
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            quot_q  <= {sa_in ^ divisor[MAG_W], {MAG_W{1'b1}}};
                            rem_q   <= '0;
                        end else begin
                            state_q <= S_DIVIDE;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                S_DIVIDE: begin
                    pr_q  <= pr_d;
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        // The last step's results go straight into the output
                        // registers, so they become valid in the same cycle as done
                        state_q <= S_FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        quot_q  <= {(sa_q ^ sb_q) & (|sr_d), sr_d};
                        rem_q   <= {sa_q & (|rem_mag_d), rem_mag_d};
                    end
                end

                S_FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sm_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_sm_seq_divider
// Self-checking bench for sm_seq_divider. It uses directed cases and
// randomized operations. Expected results come from integer / and % applied
// to the operand magnitudes, followed by the sign rules.
// -----------------------------------------------------------------------------
module tb_sm_seq_divider;

    localparam int MAG_W = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [20:0] dividend = '0;
    logic [20:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [20:0] quotient;
    logic [20:0] remainder;
    logic        div_by_zero;

    int tests_run = 0;
    int tests_failed = 0;

    sm_seq_divider #(.MAG_W(MAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the magnitudes plus the sign rules
    task automatic model(input logic [20:0] a, input logic [20:0] b,
                         output logic [20:0] q, output logic [20:0] r, output logic z);
        int unsigned am, bm, qm, rm;
        logic sa;
        am = a[19:0];
        bm = b[19:0];
        sa = a[20] && (am != 0);
        if (bm == 0) begin
            q = {sa ^ b[20], 20'hFFFFF};
            r = '0;
            z = 1'b1;
        end else begin
            qm = am / bm;
            rm = am % bm;
            q = {(qm != 0) && (sa ^ b[20]), qm[19:0]};
            r = {(rm != 0) && sa, rm[19:0]};
            z = 1'b0;
        end
    endtask

    // Issues one operation and observes it. Cycle k is the k-th cycle after the
    // capture edge. The task returns in the cycle after done, so a following
    // start can be issued at once. The cycle budget is bounded; a timeout
    // reports lat = 0.
    task automatic run_op(input logic [20:0] a, input logic [20:0] b,
                          output int lat, output int nbusy, output int fb, output int lb,
                          output logic [20:0] q, output logic [20:0] r, output logic z,
                          output logic held_ok);
        lat = 0; nbusy = 0; fb = 0; lb = 0;
        q = '0; r = '0; z = 1'b0; held_ok = 1'b0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 21'($urandom);
        divisor  = 21'($urandom);
        for (int k = 1; k <= 40; k++) begin
            if (busy) begin
                nbusy++;
                if (fb == 0) fb = k;
                lb = k;
            end
            if (lat != 0) begin
                held_ok = !done && (quotient === q) && (remainder === r) && (div_by_zero === z);
                break;
            end
            if (done) begin
                lat = k;
                q = quotient;
                r = remainder;
                z = div_by_zero;
            end
            @(posedge clk); #1;
        end
        $display("[TB] op %h / %h -> q=%h r=%h dbz=%0d latency=%0d busy_cycles=%0d",
                 a, b, q, r, z, lat, nbusy);
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 45'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: outputs %h expected 0", {busy, done, quotient, remainder, div_by_zero});
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 45'd0) begin
            tests_failed++;
            $display("FAIL reset_release: outputs %h expected 0", {busy, done, quotient, remainder, div_by_zero});
        end
    endtask

    task automatic test_basic();
        int lat, nb, fb, lb;
        logic [20:0] q, r;
        logic z, held;
        run_op(21'h000064, 21'h000007, lat, nb, fb, lb, q, r, z, held);
        tests_run++; if (lat !== 21) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 21", lat); end
        tests_run++; if (nb !== 20 || fb !== 1 || lb !== 20) begin tests_failed++; $display("FAIL basic_busy: got %0d cycles (%0d..%0d) expected 20 (1..20)", nb, fb, lb); end
        tests_run++; if (q !== 21'h00000E) begin tests_failed++; $display("FAIL basic_quotient: got %h expected 00000e", q); end
        tests_run++; if (r !== 21'h000002) begin tests_failed++; $display("FAIL basic_remainder: got %h expected 000002", r); end
        tests_run++; if (z !== 1'b0) begin tests_failed++; $display("FAIL basic_dbz: got %0d expected 0", z); end
        tests_run++; if (held !== 1'b1) begin tests_failed++; $display("FAIL basic_pulse_hold: got %0d expected 1", held); end
    endtask

    task automatic test_signs();
        logic [20:0] ta[4] = '{21'h100064, 21'h100064, 21'h100005, 21'h100000};
        logic [20:0] tb[4] = '{21'h000007, 21'h100007, 21'h000009, 21'h100005};
        logic [20:0] tq[4] = '{21'h10000E, 21'h00000E, 21'h000000, 21'h000000};
        logic [20:0] tr[4] = '{21'h100002, 21'h100002, 21'h100005, 21'h000000};
        int lat, nb, fb, lb;
        logic [20:0] q, r;
        logic z, held;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], lat, nb, fb, lb, q, r, z, held);
            tests_run++; if (q !== tq[i]) begin tests_failed++; $display("FAIL signs_quotient[%0d]: got %h expected %h", i, q, tq[i]); end
            tests_run++; if (r !== tr[i]) begin tests_failed++; $display("FAIL signs_remainder[%0d]: got %h expected %h", i, r, tr[i]); end
            tests_run++; if (z !== 1'b0 || lat !== 21) begin tests_failed++; $display("FAIL signs_timing[%0d]: dbz=%0d latency=%0d expected dbz=0 latency=21", i, z, lat); end
        end
    endtask

    task automatic test_extremes();
        logic [20:0] ta[5] = '{21'h0FFFFF, 21'h0FFFFF, 21'h000025, 21'h000009, 21'h100000};
        logic [20:0] tb[5] = '{21'h000001, 21'h0FFFFF, 21'h100000, 21'h000003, 21'h000000};
        logic [20:0] tq[5] = '{21'h0FFFFF, 21'h000001, 21'h1FFFFF, 21'h000003, 21'h0FFFFF};
        logic        tz[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat, nb, fb, lb, elat, enb;
        logic [20:0] q, r;
        logic z, held;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], lat, nb, fb, lb, q, r, z, held);
            elat = tz[i] ? 1 : 21;
            enb  = tz[i] ? 0 : 20;
            tests_run++; if (q !== tq[i]) begin tests_failed++; $display("FAIL extreme_quotient[%0d]: got %h expected %h", i, q, tq[i]); end
            tests_run++; if (r !== 21'h0) begin tests_failed++; $display("FAIL extreme_remainder[%0d]: got %h expected 000000", i, r); end
            tests_run++; if (z !== tz[i]) begin tests_failed++; $display("FAIL extreme_dbz[%0d]: got %0d expected %0d", i, z, tz[i]); end
            tests_run++; if (lat !== elat || nb !== enb) begin tests_failed++; $display("FAIL extreme_timing[%0d]: latency=%0d busy=%0d expected %0d/%0d", i, lat, nb, elat, enb); end
            tests_run++; if (held !== 1'b1) begin tests_failed++; $display("FAIL extreme_hold[%0d]: got %0d expected 1", i, held); end
        end
    endtask

    task automatic test_random();
        int lat, nb, fb, lb;
        logic [20:0] q, r, eq, er, a, b;
        logic z, ez, held;
        for (int i = 0; i < 40; i++) begin
            a = 21'($urandom);
            if ($urandom_range(0, 7) == 0) a[19:0] = '0;
            b = 21'($urandom);
            case ($urandom_range(0, 3))
                0: b[19:0] = 20'($urandom_range(1, 15));
                1: b[19:0] = 20'($urandom_range(1, 1023));
                2: b[19:0] = '0;
                default: ;
            endcase
            model(a, b, eq, er, ez);
            run_op(a, b, lat, nb, fb, lb, q, r, z, held);
            tests_run++; if ({q, r, z} !== {eq, er, ez}) begin tests_failed++; $display("FAIL random_result[%0d]: %h/%h got q=%h r=%h z=%0d expected q=%h r=%h z=%0d", i, a, b, q, r, z, eq, er, ez); end
            tests_run++; if (lat !== (ez ? 1 : 21) || nb !== (ez ? 0 : 20)) begin tests_failed++; $display("FAIL random_timing[%0d]: latency=%0d busy=%0d", i, lat, nb); end
        end
    endtask

    // A start during busy is ignored; a start right after FINISH is accepted
    task automatic test_handshake();
        int d1 = 0, d2 = 0, ndone = 0;
        logic [20:0] q1 = '0, r1 = '0, q2 = '0;
        dividend = 21'h000064;
        divisor  = 21'h000007;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            if (done) begin
                ndone++;
                if (d1 == 0) begin d1 = k; q1 = quotient; r1 = remainder; end
                else if (d2 == 0) begin d2 = k; q2 = quotient; end
            end
            start = (k == 5) || (k == 22);
            if (start) begin
                dividend = 21'h000009;
                divisor  = 21'h000003;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        $display("[TB] handshake: done at %0d and %0d, q1=%h r1=%h q2=%h", d1, d2, q1, r1, q2);
        tests_run++; if (ndone !== 2) begin tests_failed++; $display("FAIL handshake_done_count: got %0d expected 2", ndone); end
        tests_run++; if (d1 !== 21 || {q1, r1} !== {21'h00000E, 21'h000002}) begin tests_failed++; $display("FAIL handshake_ignored_start: done at %0d q=%h r=%h expected 21 00000e 000002", d1, q1, r1); end
        tests_run++; if (d2 !== 43 || q2 !== 21'h000003) begin tests_failed++; $display("FAIL handshake_back_to_back: done at %0d q=%h expected 43 000003", d2, q2); end
    endtask

    task automatic test_reset_mid_op();
        int ndone = 0;
        int lat, nb, fb, lb;
        logic [20:0] q, r;
        logic z, held;
        dividend = 21'h000064;
        divisor  = 21'h000007;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 45'd0) begin
            tests_failed++;
            $display("FAIL midop_reset_outputs: got %h expected 0", {busy, done, quotient, remainder, div_by_zero});
        end
        @(posedge clk);
        #3 rst = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        $display("[TB] reset mid-operation: %0d cycles with done/busy after release", ndone);
        tests_run++; if (ndone !== 0) begin tests_failed++; $display("FAIL midop_no_done: got %0d active cycles expected 0", ndone); end
        run_op(21'h000024, 21'h000005, lat, nb, fb, lb, q, r, z, held);
        tests_run++; if (lat !== 21 || {q, r, z} !== {21'h000007, 21'h000001, 1'b0}) begin tests_failed++; $display("FAIL midop_recovery: latency=%0d q=%h r=%h z=%0d expected 21 000007 000001 0", lat, q, r, z); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_extremes();
        test_random();
        test_handshake();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
